// File: rtl/tff_counter_ctrl.sv
// tff_counter_ctrl
//   Sequencer for a bank of W external T flip-flops that together form a
//   modulo-N up/down counter. The bank shares clk and rst_n with this block
//   and updates on the same edge. Every count, wrap and load is therefore
//   expressed as a toggle pattern: t_out = q_now ^ q_next, qualified by en_out.
//
// Parameters
//   W         counter width (number of TFF bits), W >= 2
//
// Ports
//   clk       system clock, rising edge, shared with the TFF bank
//   rst_n     asynchronous active-low reset, shared with the TFF bank
//   start     level: IDLE/DONE/HOLD -> RUN (no count step on that cycle)
//   stop      level: RUN -> HOLD
//   abort     level: any state -> IDLE, count untouched
//   up_dn     1 = count up, 0 = count down
//   one_shot  1 = go to DONE on the first wrap, 0 = keep running
//   load      load load_val into the bank this cycle (no count step)
//   load_val  value to load (loaded as given, even if >= modulus)
//   modulus   count modulus N; 0 means 2^W
//   q_in      current q of the TFF bank
//   en_out    enable to all TFFs
//   t_out     per-bit toggle to the TFFs
//   busy      state is RUN or HOLD
//   tc        one-cycle pulse in the cycle after a wrap edge
//   done      one-cycle pulse in the cycle after entering DONE
module tff_counter_ctrl #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         stop,
  input  logic         abort,
  input  logic         up_dn,
  input  logic         one_shot,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] modulus,
  input  logic [W-1:0] q_in,
  output logic         en_out,
  output logic [W-1:0] t_out,
  output logic         busy,
  output logic         tc,
  output logic         done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e state_q, state_d;
  logic   tc_q, tc_d;
  logic   done_q, done_d;

  // Terminal value M: the last count before a wrap. modulus = 0 selects the
  // full 2^W range, so M becomes all ones.
  function automatic logic [W-1:0] terminal_val(input logic [W-1:0] m);
    logic [W-1:0] r;
    if (m == '0) r = '1;
    else         r = m - 1'b1;
    return r;
  endfunction

  // Toggle pattern for +1: bit i flips when all lower bits are 1.
  function automatic logic [W-1:0] inc_toggles(input logic [W-1:0] q);
    logic [W-1:0] r;
    logic         carry;
    carry = 1'b1;
    for (int i = 0; i < W; i++) begin
      r[i]  = carry;
      carry = carry & q[i];
    end
    return r;
  endfunction

  // Toggle pattern for -1: bit i flips when all lower bits are 0.
  function automatic logic [W-1:0] dec_toggles(input logic [W-1:0] q);
    logic [W-1:0] r;
    logic         borrow;
    borrow = 1'b1;
    for (int i = 0; i < W; i++) begin
      r[i]   = borrow;
      borrow = borrow & ~q[i];
    end
    return r;
  endfunction

  logic [W-1:0] term;
  assign term = terminal_val(modulus);

  always_comb begin
    state_d = state_q;
    en_out  = 1'b0;
    t_out   = '0;
    tc_d    = 1'b0;
    done_d  = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
    end else if (load) begin
      // Load overrides counting and keeps the state, except that a finished
      // one-shot drops back to IDLE once its count is overwritten.
      en_out = 1'b1;
      t_out  = q_in ^ load_val;
      if (state_q == S_DONE) state_d = S_IDLE;
    end else if (stop && (state_q == S_RUN)) begin
      state_d = S_HOLD;
    end else if (start && (state_q != S_RUN)) begin
      state_d = S_RUN;
    end else if (state_q == S_RUN) begin
      en_out = 1'b1;
      if (up_dn) begin
        // q_in >= M (including out-of-range loaded values) forces the wrap
        // to 0; toggling every set bit clears the bank.
        if (q_in >= term) begin
          t_out = q_in;
          tc_d  = 1'b1;
        end else begin
          t_out = inc_toggles(q_in);
        end
      end else begin
        // From 0 the bank wraps to M; values above M simply decrement.
        if (q_in == '0) begin
          t_out = term;
          tc_d  = 1'b1;
        end else begin
          t_out = dec_toggles(q_in);
        end
      end
      if (tc_d && one_shot) begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == S_RUN) || (state_q == S_HOLD);
  assign tc   = tc_q;
  assign done = done_q;

endmodule

// File: tb/tb_tff_counter_ctrl.sv
module tb_tff_counter_ctrl;
  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;
  localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2, M_DONE = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 0, stop = 0, abort = 0, up_dn = 1, one_shot = 0, load = 0;
  logic [W-1:0] load_val = '0, modulus = '0;
  logic [W-1:0] bank_q;
  logic         en_out, busy, tc, done;
  logic [W-1:0] t_out;

  tff_counter_ctrl #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .abort(abort),
    .up_dn(up_dn), .one_shot(one_shot), .load(load), .load_val(load_val),
    .modulus(modulus), .q_in(bank_q), .en_out(en_out), .t_out(t_out),
    .busy(busy), .tc(tc), .done(done)
  );

  // The external T flip-flop bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      bank_q <= '0;
    else if (en_out) bank_q <= bank_q ^ t_out;
  end

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: controller state plus the counter value it should hold.
  int mstate = M_IDLE;
  int mq = 0;
  int mtc = 0;
  int mdone = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: predict from the spec rules, compare DUT outputs,
  // then advance the model across the rising edge.
  task automatic step();
    int  mv, qn, sn;
    bit  en, wrap;
    #1;
    mv   = (modulus == 0) ? MAXV : int'(modulus) - 1;
    en   = 0;
    wrap = 0;
    qn   = mq;
    sn   = mstate;
    if (abort) begin
      sn = M_IDLE;
    end else if (load) begin
      en = 1;
      qn = int'(load_val);
      if (mstate == M_DONE) sn = M_IDLE;
    end else if (stop && mstate == M_RUN) begin
      sn = M_HOLD;
    end else if (start && mstate != M_RUN) begin
      sn = M_RUN;
    end else if (mstate == M_RUN) begin
      en = 1;
      if (up_dn) begin
        if (mq >= mv) begin qn = 0; wrap = 1; end
        else qn = mq + 1;
      end else begin
        if (mq == 0) begin qn = mv; wrap = 1; end
        else qn = mq - 1;
      end
      if (wrap && one_shot) sn = M_DONE;
    end
    chk("q", 32'(bank_q), 32'(mq));
    chk("en_out", 32'(en_out), 32'(en));
    chk("t_out", 32'(t_out), en ? 32'(mq ^ qn) : 32'd0);
    chk("busy", 32'(busy), 32'(mstate == M_RUN || mstate == M_HOLD));
    chk("tc", 32'(tc), 32'(mtc));
    chk("done", 32'(done), 32'(mdone));
    @(posedge clk);
    mq     = qn;
    mstate = sn;
    mtc    = wrap;
    mdone  = wrap && one_shot;
    @(negedge clk);
  endtask

  task automatic clear_ctrl();
    start = 0; stop = 0; abort = 0; load = 0;
  endtask

  // Asynchronous reset pulse mid-cycle, released before the next rising edge.
  task automatic do_reset();
    clear_ctrl();
    rst_n = 1'b0;
    #2;
    chk("rst_q", 32'(bank_q), 32'd0);
    chk("rst_en", 32'(en_out), 32'd0);
    chk("rst_t", 32'(t_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tc", 32'(tc), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    mstate = M_IDLE; mq = 0; mtc = 0; mdone = 0;
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    #1;
    do_reset();

    // 1: modulus 10, continuous, up.
    modulus = 4'd10; up_dn = 1; one_shot = 0; start = 1;
    step();
    start = 0;
    repeat (9) step();
    #1;
    chk("t1_q9", 32'(bank_q), 32'd9);
    chk("t1_t_wrap", 32'(t_out), 32'b1001);
    step();
    #1;
    chk("t1_q0", 32'(bank_q), 32'd0);
    chk("t1_tc", 32'(tc), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);

    // 2: modulus 0 (full range), down from 0.
    modulus = 4'd0; up_dn = 0;
    #1;
    chk("t2_t_at0", 32'(t_out), 32'b1111);
    step();
    #1;
    chk("t2_q15", 32'(bank_q), 32'd15);
    chk("t2_tc", 32'(tc), 32'd1);

    // 3: one-shot, modulus 5, up from 0.
    up_dn = 1; one_shot = 1; modulus = 4'd5; abort = 1;
    step();
    abort = 0; load = 1; load_val = 4'd0;
    step();
    load = 0; start = 1;
    step();
    start = 0;
    repeat (4) step();
    #1;
    chk("t3_t_wrap", 32'(t_out), 32'b0100);
    step();
    #1;
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_tc", 32'(tc), 32'd1);
    chk("t3_q", 32'(bank_q), 32'd0);
    chk("t3_busy", 32'(busy), 32'd0);
    step();
    #1;
    chk("t3_done_once", 32'(done), 32'd0);
    chk("t3_q_frozen", 32'(bank_q), 32'd0);

    // 4: load 12 with stop at q = 3.
    one_shot = 0; modulus = 4'd10; start = 1;
    step();
    start = 0;
    repeat (3) step();
    load = 1; load_val = 4'd12; stop = 1;
    #1;
    chk("t4_t", 32'(t_out), 32'b1111);
    step();
    load = 0;
    #1;
    chk("t4_q12", 32'(bank_q), 32'd12);
    chk("t4_en_stop", 32'(en_out), 32'd0);
    step();
    #1;
    chk("t4_hold_busy", 32'(busy), 32'd1);
    chk("t4_no_tc", 32'(tc), 32'd0);

    // 5: load 9 with modulus 6, count up forces a wrap to 0.
    stop = 0; modulus = 4'd6; load = 1; load_val = 4'd9;
    step();
    load = 0; start = 1;
    step();
    start = 0;
    #1;
    chk("t5_t", 32'(t_out), 32'b1001);
    step();
    #1;
    chk("t5_q0", 32'(bank_q), 32'd0);
    chk("t5_tc", 32'(tc), 32'd1);

    // 6: reset mid-RUN at q = 7, then abort in HOLD.
    modulus = 4'd10; load = 1; load_val = 4'd7;
    step();
    load = 0;
    #1;
    chk("t6_q7", 32'(bank_q), 32'd7);
    do_reset();
    start = 1;
    step();
    start = 0;
    repeat (2) step();
    stop = 1;
    step();
    stop = 0; abort = 1;
    step();
    abort = 0;
    #1;
    chk("t6_abort_q", 32'(bank_q), 32'd2);
    chk("t6_abort_busy", 32'(busy), 32'd0);
    step();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      abort    = ($urandom_range(0, 39) == 0);
      load     = ($urandom_range(0, 14) == 0);
      stop     = ($urandom_range(0, 14) == 0);
      start    = ($urandom_range(0, 5) == 0);
      load_val = W'($urandom);
      if ($urandom_range(0, 7) == 0) up_dn = ~up_dn;
      if ($urandom_range(0, 19) == 0) one_shot = ~one_shot;
      if ($urandom_range(0, 29) == 0) modulus = W'($urandom_range(0, 3) == 0 ? $urandom_range(0, 2) : $urandom);
      if ($urandom_range(0, 499) == 0) do_reset();
      else step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
